// File: rtl/kan_tda_result_aggregator.sv
// Collects fixed-size result blocks from KAN/TDA producer channels in round-robin order
// and streams them word by word, tagged with the source channel, through an output FIFO.
module kan_tda_result_aggregator #(
  parameter int NUM_CH       = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int WORDS_PER_CH = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int THERM_HI     = 200,
  parameter int THERM_LO     = 180
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       enable,
  input  logic [NUM_CH-1:0]                          ch_mask,
  input  logic [NUM_CH-1:0]                          ch_valid,
  input  logic [NUM_CH*WORDS_PER_CH*DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CH-1:0]                          ch_ready,
  output logic                                       out_valid,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic [$clog2(NUM_CH)-1:0]                  out_ch_id,
  input  logic                                       out_ready,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_level,
  output logic                                       busy,
  output logic                                       sweep_done,
  output logic                                       sweep_abort,
  output logic [7:0]                                 thermal_level,
  output logic                                       thermal_alarm
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int WI_W  = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CH_W:0]    NCH_L    = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [WI_W-1:0]  LAST_WI  = WI_W'(WORDS_PER_CH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(FIFO_DEPTH / 2);
  localparam logic [7:0]       T_HI     = 8'(THERM_HI);
  localparam logic [7:0]       T_LO     = 8'(THERM_LO);
  localparam logic [7:0]       T_RST    = 8'd150;

  typedef enum logic [1:0] {IDLE, SCAN, XFER, DONE} state_e;
  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_CH-1:0][WORDS_PER_CH-1:0][DATA_WIDTH-1:0] ch_words;
  assign ch_words = ch_data;

  state_e                                  state_q, state_d;
  logic [NUM_CH-1:0]                       pending_q, pending_d;
  logic [CH_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]                         sel_q, sel_d;
  logic [WI_W-1:0]                         widx_q, widx_d;
  logic [WORDS_PER_CH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic                                    abort_req_q, abort_req_d;
  logic                                    sweep_abort_q, sweep_abort_d;
  logic                                    last_push_q, last_push_d;
  logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]                        level_q, level_d;
  logic [7:0]                              therm_q, therm_d;
  logic                                    alarm_q, alarm_d;
  entry_t                                  mem_q [FIFO_DEPTH];
  entry_t                                  head, push_entry;
  logic                                    push, pop, full, found;
  logic [CH_W:0]                           cand_sum;
  logic [CH_W-1:0]                         cand, pick;

  // Round-robin search starting at rr_ptr, wrapping at NUM_CH (need not be a power of 2).
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (cand_sum >= NCH_L) cand_sum = cand_sum - NCH_L;
      cand = cand_sum[CH_W-1:0];
      if (!found && pending_q[cand] && ch_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    rr_ptr_d      = rr_ptr_q;
    sel_d         = sel_q;
    widx_d        = widx_q;
    buf_d         = buf_q;
    abort_req_d   = abort_req_q;
    sweep_abort_d = 1'b0;
    ch_ready      = '0;
    push          = 1'b0;
    unique case (state_q)
      IDLE: if (enable && (ch_mask != '0)) begin
        pending_d = ch_mask;
        state_d   = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_d       = IDLE;
          sweep_abort_d = 1'b1;
        end else if (found) begin
          ch_ready[pick] = 1'b1;
          buf_d          = ch_words[pick];
          sel_d          = pick;
          widx_d         = '0;
          abort_req_d    = 1'b0;
          state_d        = XFER;
        end
      end
      XFER: begin
        // A dropped enable is remembered; the channel in flight still completes.
        if (!enable) abort_req_d = 1'b1;
        if (!full && (!alarm_q || !last_push_q)) begin
          push = 1'b1;
          if (widx_q == LAST_WI) begin
            pending_d[sel_q] = 1'b0;
            rr_ptr_d         = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
            abort_req_d      = 1'b0;
            if (abort_req_q || !enable) begin
              state_d       = IDLE;
              sweep_abort_d = 1'b1;
            end else if (pending_d == '0) begin
              state_d = DONE;
            end else begin
              state_d = SCAN;
            end
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  always_comb begin
    full        = (level_q == FULL_LVL);
    pop         = out_valid && out_ready;
    push_entry  = '{ch: sel_q, data: buf_q[widx_q]};
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    last_push_d = push;
  end

  always_comb begin
    therm_d = therm_q;
    if ((state_q != IDLE) && (level_q >= HALF_LVL)) begin
      if (therm_q != 8'hFF) therm_d = therm_q + 1'b1;
    end else if (state_q == IDLE) begin
      if (therm_q != 8'h00) therm_d = therm_q - 1'b1;
    end
    alarm_d = alarm_q;
    if (therm_q >= T_HI) alarm_d = 1'b1;
    else if (therm_q < T_LO) alarm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      sel_q         <= '0;
      widx_q        <= '0;
      buf_q         <= '0;
      abort_req_q   <= 1'b0;
      sweep_abort_q <= 1'b0;
      last_push_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      therm_q       <= T_RST;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_q         <= sel_d;
      widx_q        <= widx_d;
      buf_q         <= buf_d;
      abort_req_q   <= abort_req_d;
      sweep_abort_q <= sweep_abort_d;
      last_push_q   <= last_push_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      therm_q       <= therm_d;
      alarm_q       <= alarm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_valid     = (level_q != '0);
  assign out_data      = out_valid ? head.data : '0;
  assign out_ch_id     = out_valid ? head.ch : '0;
  assign fifo_level    = level_q;
  assign busy          = (state_q != IDLE);
  assign sweep_done    = (state_q == DONE);
  assign sweep_abort   = sweep_abort_q;
  assign thermal_level = therm_q;
  assign thermal_alarm = alarm_q;

endmodule

// File: tb/tb_kan_tda_result_aggregator.sv
// Scoreboard bench: channel grants queue the expected words, a negedge monitor checks
// order, tags, FIFO occupancy rules and the thermal/throttle behaviour.
module tb_kan_tda_result_aggregator;
  localparam int NCH = 16, DW = 16, WPC = 4, FD = 16, THI = 200, TLO = 180;

  logic                    clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [NCH-1:0]          ch_mask = '0, ch_valid = '0, ch_ready;
  logic [NCH*WPC*DW-1:0]   ch_data = '0;
  logic                    out_valid, busy, sweep_done, sweep_abort, thermal_alarm;
  logic [DW-1:0]           out_data;
  logic [3:0]              out_ch_id;
  logic [4:0]              fifo_level;
  logic [7:0]              thermal_level;

  kan_tda_result_aggregator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_ready(ch_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch_id(out_ch_id), .out_ready(out_ready), .fifo_level(fifo_level), .busy(busy),
    .sweep_done(sweep_done), .sweep_abort(sweep_abort), .thermal_level(thermal_level),
    .thermal_alarm(thermal_alarm));

  always #5 clk = ~clk;

  typedef struct { int ch; int data; } exp_t;
  exp_t sb[$];
  int   served_q[$];
  int   vecs = 0, errs = 0;
  int   done_cnt = 0, abort_cnt = 0, pop_cnt = 0, alarm_push_cnt = 0;
  logic [NCH-1:0] m_pend = '0;
  int   m_rr = 0, m_therm = 150;
  bit   m_alarm = 0;
  int   prev_level = 0;
  bit   prev_pop = 0, prev_alarm = 0, prev_push = 0, hist_ok = 0;
  bit   rnd_valid = 0, rnd_ready = 0;

  task automatic fail(input string name, input longint act, input longint exp);
    errs++;
    $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) fail(name, act, exp);
  endtask

  task automatic timeout(input string name);
    vecs++;
    fail({name, "_timeout"}, 0, 1);
  endtask

  // Reference arbitration: first pending & valid channel at or after the round-robin pointer.
  function automatic int model_pick();
    for (int i = 0; i < NCH; i++) begin
      int k = (m_rr + i) % NCH;
      if (m_pend[k] && ch_valid[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH*WPC*DW/32; i++) ch_data[i*32 +: 32] = $urandom;
    if (rnd_valid) ch_valid = NCH'($urandom);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin : mon
    int pushed, c;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_pend = '0; m_rr = 0; m_therm = 150; m_alarm = 0;
      hist_ok = 0; prev_push = 0;
    end else begin
      chk("thermal_level", thermal_level, m_therm);
      chk("thermal_alarm", thermal_alarm, m_alarm);
      chk("fifo_level_over", fifo_level > FD, 0);
      if (hist_ok) begin
        pushed = int'(fifo_level) - prev_level + int'(prev_pop);
        chk("push_per_cycle", (pushed == 0 || pushed == 1), 1);
        if (prev_level == FD) chk("push_when_full", pushed, 0);
        if (prev_alarm && prev_push) chk("throttle", pushed, 0);
        if (prev_alarm && pushed == 1) alarm_push_cnt++;
        prev_push = (pushed == 1);
      end
      if (ch_ready != '0) begin
        c = 0;
        for (int i = NCH-1; i >= 0; i--) if (ch_ready[i]) c = i;
        chk("ch_ready_onehot", $onehot(ch_ready), 1);
        chk("ch_select", c, model_pick());
        for (int w = 0; w < WPC; w++) begin
          e.ch = c;
          e.data = int'(ch_data[(c*WPC + w)*DW +: DW]);
          sb.push_back(e);
        end
        m_pend[c] = 1'b0;
        m_rr = (c + 1) % NCH;
        served_q.push_back(c);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          vecs++;
          fail("unexpected_word", int'(out_data), -1);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ch_id", out_ch_id, e.ch);
        end
      end
      if (sweep_done) done_cnt++;
      if (sweep_abort) abort_cnt++;
      if (m_therm >= THI) m_alarm = 1;
      else if (m_therm < TLO) m_alarm = 0;
      if (busy && fifo_level >= FD/2) begin
        if (m_therm < 255) m_therm++;
      end else if (!busy) begin
        if (m_therm > 0) m_therm--;
      end
      prev_level = int'(fifo_level);
      prev_pop   = out_valid && out_ready;
      prev_alarm = thermal_alarm;
      hist_ok    = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_neg();
    @(negedge clk); #1;
  endtask

  task automatic start(input logic [NCH-1:0] mask);
    tick();
    ch_mask = mask;
    m_pend  = mask;
    enable  = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int n = 0;
    while (done_cnt == d0 && n < bound) begin wait_neg(); n++; end
    if (done_cnt == d0) timeout("sweep_done");
    tick();
    enable = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || fifo_level != 0) && n < bound) begin wait_neg(); n++; end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_fifo_level", fifo_level, 0);
  endtask

  initial begin : stim
    int d0, a0, p0, n;
    logic [NCH-1:0] m;

    // Reset values
    repeat (3) tick();
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch_id", out_ch_id, 0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_sweep_abort", sweep_abort, 0);
    chk("rst_thermal", thermal_level, 150);
    chk("rst_alarm", thermal_alarm, 0);
    rst_n = 1'b1;

    // Two-channel sweep, everything available
    ch_valid = '1; out_ready = 1'b1;
    served_q.delete(); d0 = done_cnt;
    start(16'h0005);
    wait_done(d0, 200);
    drain(100);
    repeat (3) wait_neg();
    chk("s1_served_n", served_q.size(), 2);
    if (served_q.size() == 2) begin
      chk("s1_first", served_q[0], 0);
      chk("s1_second", served_q[1], 2);
    end
    chk("s1_done_pulses", done_cnt - d0, 1);

    // All channels with a blocked consumer: fill, stall, heat up, then release
    out_ready = 1'b0; served_q.delete(); d0 = done_cnt;
    start(16'hFFFF);
    repeat (60) wait_neg();
    chk("full_level", fifo_level, FD);
    chk("full_busy", busy, 1);
    n = 0;
    while (!thermal_alarm && n < 400) begin wait_neg(); n++; end
    if (!thermal_alarm) timeout("alarm_set");
    chk("alarm_level", thermal_level >= THI, 1);
    p0 = alarm_push_cnt;
    tick(); out_ready = 1'b1;
    wait_done(d0, 1500);
    drain(200);
    chk("full_served_n", served_q.size(), 16);
    chk("throttled_pushes_seen", alarm_push_cnt > p0, 1);
    n = 0;
    while (thermal_alarm && n < 400) begin wait_neg(); n++; end
    if (thermal_alarm) timeout("alarm_clear");
    chk("alarm_clear_level", thermal_level < TLO, 1);

    // Channel 0 late: channel 1 goes first
    ch_valid = 16'hFFFE; served_q.delete(); d0 = done_cnt;
    start(16'h0003);
    repeat (20) tick();
    ch_valid = '1;
    wait_done(d0, 200);
    drain(100);
    chk("late_served_n", served_q.size(), 2);
    if (served_q.size() == 2) begin
      chk("late_first", served_q[0], 1);
      chk("late_second", served_q[1], 0);
    end

    // Enable dropped in the second transfer cycle
    served_q.delete(); d0 = done_cnt; a0 = abort_cnt; p0 = pop_cnt;
    start(16'h0030);
    n = 0;
    while (ch_ready == '0 && n < 100) begin wait_neg(); n++; end
    if (ch_ready == '0) timeout("xfer_grant");
    tick(); tick();
    enable = 1'b0;
    n = 0;
    while (abort_cnt == a0 && n < 100) begin wait_neg(); n++; end
    drain(100);
    repeat (3) wait_neg();
    chk("xabort_pulses", abort_cnt - a0, 1);
    chk("xabort_no_done", done_cnt - d0, 0);
    chk("xabort_words", pop_cnt - p0, WPC);
    chk("xabort_served", served_q.size(), 1);
    chk("xabort_idle", busy, 0);

    // Enable dropped while scanning with nothing valid
    ch_valid = '0; a0 = abort_cnt; served_q.delete();
    start(16'h0100);
    repeat (5) tick();
    enable = 1'b0;
    repeat (4) wait_neg();
    chk("sabort_pulses", abort_cnt - a0, 1);
    chk("sabort_idle", busy, 0);
    chk("sabort_no_grant", served_q.size(), 0);

    // Empty mask keeps the block idle
    start('0);
    repeat (3) begin wait_neg(); chk("zero_mask_idle", busy, 0); end
    tick(); enable = 1'b0;

    // Randomized sweeps
    rnd_valid = 1; rnd_ready = 1;
    for (int s = 0; s < 12; s++) begin
      m = NCH'($urandom);
      if (m == '0) m = 16'h8000;
      served_q.delete(); d0 = done_cnt;
      start(m);
      wait_done(d0, 3000);
      chk("rand_served_n", served_q.size(), $countones(m));
    end
    drain(500);
    rnd_valid = 0; rnd_ready = 0;

    // Asynchronous reset in the middle of a transfer
    ch_valid = '1; out_ready = 1'b0;
    start(16'h0003);
    n = 0;
    while (fifo_level != 5 && n < 100) begin wait_neg(); n++; end
    chk("mid_level5", fifo_level, 5);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_thermal", thermal_level, 150);
    chk("mid_rst_valid", out_valid, 0);
    enable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) wait_neg();
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual %0d, required %0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

endmodule
